// File: rtl/alsu_req_arbiter.sv
// Round-robin front end sharing one ALSU between two requesters; one op in flight at a time.
// Optional build macro ALSU_ARB_ERRCHK_EN enables the illegal-op flag on rsp_err.
module alsu_req_arbiter #(
  parameter int         LATENCY = 2,
  parameter logic [2:0] PARK_A  = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_a,
  input  logic [2:0] req0_b,
  input  logic [2:0] req0_opcode,
  input  logic [6:0] req0_ctrl,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_a,
  input  logic [2:0] req1_b,
  input  logic [2:0] req1_opcode,
  input  logic [6:0] req1_ctrl,
  output logic [2:0] alsu_a,
  output logic [2:0] alsu_b,
  output logic [2:0] alsu_opcode,
  output logic [6:0] alsu_ctrl,
  input  logic [5:0] alsu_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [5:0] rsp_data,
  output logic       rsp_err,
  output logic       busy
);

  localparam int         NUM_REQ   = 2;
  localparam logic [2:0] WAIT_LAST = 3'(LATENCY - 1);
  // ctrl packing: {cin,serial_in,red_op_A,red_op_B,bypass_A,bypass_B,direction}
  localparam logic [6:0] PARK_CTRL = 7'b0000100;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] opcode;
    logic [6:0] ctrl;
  } alsu_req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                   state, state_nxt;
  alsu_req_t [NUM_REQ-1:0]  req_in;
  logic      [NUM_REQ-1:0]  req_valid;
  logic      [NUM_REQ-1:0]  req_ready;
  alsu_req_t                op_q;
  logic                     id_q;
  logic                     last_id;
  logic                     grant_id;
  logic                     accept;
  logic                     wait_last;
  logic      [2:0]          wait_cnt;

  assign req_in[0]  = {req0_a, req0_b, req0_opcode, req0_ctrl};
  assign req_in[1]  = {req1_a, req1_b, req1_opcode, req1_ctrl};
  assign req_valid  = {req1_valid, req0_valid};
  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  // On a tie the requester not served last wins; otherwise the lone requester.
  always_comb begin
    if (&req_valid) grant_id = ~last_id;
    else            grant_id = req_valid[1];
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign req_ready[g] = (state == IDLE) && !rst && req_valid[g] && (grant_id == 1'(g));
  end

  assign accept    = |req_ready;
  assign wait_last = (state == WAIT) && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = ISSUE;
      ISSUE:                  state_nxt = WAIT;
      WAIT:    if (wait_last) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Park drives a bypass of PARK_A so shift/rotate ops start from a known value.
  always_comb begin
    rsp_valid   = (state == RESP);
    busy        = (state != IDLE);
    alsu_a      = PARK_A;
    alsu_b      = 3'b000;
    alsu_opcode = 3'b000;
    alsu_ctrl   = PARK_CTRL;
    if (state == ISSUE) begin
      alsu_a      = op_q.a;
      alsu_b      = op_q.b;
      alsu_opcode = op_q.opcode;
      alsu_ctrl   = op_q.ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      id_q     <= 1'b0;
      wait_cnt <= 3'd0;
      rsp_id   <= 1'b0;
      rsp_data <= 6'd0;
      last_id  <= 1'b1;
    end else begin
      if (accept) begin
        op_q <= req_in[grant_id];
        id_q <= grant_id;
      end
      if (state == ISSUE)     wait_cnt <= 3'd0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 3'd1;
      if (wait_last) begin
        rsp_data <= alsu_out;
        rsp_id   <= id_q;
      end
      if (rsp_valid && rsp_ready) last_id <= rsp_id;
    end
  end

`ifdef ALSU_ARB_ERRCHK_EN
  logic op_illegal;

  // Reduction is only meaningful for AND/XOR; 110/111 are undefined unless bypassed.
  always_comb begin
    op_illegal = !(op_q.ctrl[2] | op_q.ctrl[1]) &&
                 ((op_q.opcode[2:1] == 2'b11) ||
                  ((op_q.opcode >= 3'd2) && (op_q.ctrl[4] | op_q.ctrl[3])));
  end

  always_ff @(posedge clk) begin
    if (rst)            rsp_err <= 1'b0;
    else if (wait_last) rsp_err <= op_illegal;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule
